// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and frame defaults shared with the transmitter.
package uart_pkg;
  localparam int WORD_SIZE_DEF   = 8;
  localparam int PULSE_WIDTH_DEF = 868;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_meta <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
endmodule

// File: rtl/receiver.sv
// receiver: UART frame deserialiser (start, WORD_SIZE data bits LSB first, one stop bit).
module receiver import uart_pkg::*; #(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int PULSE_WIDTH = PULSE_WIDTH_DEF,
  parameter int PACKET_SIZE = WORD_SIZE + 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [WORD_SIZE-1:0] data_bits,
  output logic                 rx_valid
);
  localparam int CW = $clog2(PULSE_WIDTH);
  localparam int IW = $clog2(WORD_SIZE + 1);
  localparam logic [CW-1:0] C_FULL = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] C_HALF = CW'(PULSE_WIDTH / 2 - 1);
  localparam logic [IW-1:0] I_LAST = IW'(PACKET_SIZE - 3);
  logic                 w_rx_s;
  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [WORD_SIZE-1:0] r_shift;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (rx),
    .o_q  (w_rx_s)
  );
  // Shifting in from the top leaves the first data bit in bit 0 after WORD_SIZE samples.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      data_bits <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (r_state)
        IDLE:
          if (!w_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        START:
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rx_s ? IDLE : DATA;
          end else r_cnt <= r_cnt + 1'b1;
        DATA:
          if (r_cnt == C_FULL) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[WORD_SIZE-1:1]};
            r_idx   <= r_idx + 1'b1;
            if (r_idx == I_LAST) r_state <= STOP;
          end else r_cnt <= r_cnt + 1'b1;
        STOP:
          if (r_cnt == C_FULL) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              data_bits <= r_shift;
              rx_valid  <= 1'b1;
              r_state   <= IDLE;
            end else r_state <= WAIT_IDLE;
          end else r_cnt <= r_cnt + 1'b1;
        WAIT_IDLE:
          if (w_rx_s) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: random-gap UART frames checked against a frame-level expectation model.
module tb_receiver;
  localparam int PW = 4;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_bits;
  logic       rx_valid;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         cyc_q[$];
  logic [7:0] last_good = 8'h00;
  receiver #(.WORD_SIZE(8), .PULSE_WIDTH(PW), .PACKET_SIZE(10)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .data_bits (data_bits),
    .rx_valid  (rx_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (rx_valid === 1'b1) begin
      got_q.push_back(data_bits);
      cyc_q.push_back(cyc);
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] w, input logic stop);
    logic [9:0] bits;
    bits = {stop, w, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (PW) @(negedge clk);
    end
  endtask
  task automatic expect_frame(input logic [7:0] w);
    repeat (8) @(negedge clk);
    chk("pulse_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("word", got_q[0], w);
    got_q.delete();
    cyc_q.delete();
    last_good = w;
    chk("data_hold", data_bits, last_good);
    repeat ($urandom_range(1, 50)) @(negedge clk);
  endtask
  initial begin
    logic [7:0] words[7] = '{8'h55, 8'hA3, 8'h7E, 8'hC3, 8'h81, 8'h00, 8'hFF};
    repeat (3) @(negedge clk);
    chk("rst_data", data_bits, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    foreach (words[i]) begin
      send_frame(words[i], 1'b1);
      expect_frame(words[i]);
    end
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_none", got_q.size(), 0);
    send_frame(8'h5A, 1'b1);
    expect_frame(8'h5A);
    send_frame(8'h3C, 1'b0);
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("ferr_none", got_q.size(), 0);
    chk("ferr_hold", data_bits, last_good);
    send_frame(8'h1E, 1'b1);
    expect_frame(8'h1E);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (16) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_data", data_bits, 8'h00);
        chk("arst_valid", rx_valid, 1'b0);
      end
    join
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_none", got_q.size(), 0);
    send_frame(8'hA3, 1'b1);
    expect_frame(8'hA3);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    repeat (8) @(negedge clk);
    chk("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("b2b_first", got_q[0], 8'h55);
      chk("b2b_second", got_q[1], 8'hAA);
      chk("b2b_spacing", cyc_q[1] - cyc_q[0], 10 * PW);
    end
    chk("b2b_hold", data_bits, 8'hAA);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
